// File: rtl/mem_port_arbiter.sv
// Shares the core's single memory port between instruction fetch and the LSU.
// LSU has priority; a starvation counter forces a fetch grant after STARVE_LIMIT LSU wins.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rdata,
    output logic        if_err,

    input  logic        lsu_req,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_we,
    input  logic [31:0] lsu_wdata,
    input  logic [1:0]  lsu_width,
    output logic        lsu_rsp_valid,
    output logic [31:0] lsu_rdata,
    output logic        lsu_err,

    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS_IF  = 2'd1,
        BUS_LSU = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [SW-1:0] starve_cnt, starve_d;
    logic [TW-1:0] to_cnt, to_d;
    logic          post_resp, post_resp_d;
    logic [1:0]    lsu_shift, lsu_shift_d;

    logic          if_rsp_valid_d, if_err_d, lsu_rsp_valid_d, lsu_err_d;
    logic [31:0]   if_rdata_d, lsu_rdata_d;
    logic          mem_req_d, mem_we_d;
    logic [31:0]   mem_addr_d, mem_wdata_d;
    logic [3:0]    mem_be_d;

    logic          lsu_misaligned;
    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata;
    logic          starve_at_limit;
    logic          lsu_wins;
    logic [SW-1:0] starve_on_lsu;
    logic          to_last;
    logic [31:0]   read_shifted;

    // Fetch is always word-aligned; the low address bits carry no information.
    logic unused_if_addr_lo;
    assign unused_if_addr_lo = ^if_addr[1:0];

    // Lane placement and alignment check for the LSU request.
    always_comb begin
        lsu_misaligned = 1'b0;
        lane_be        = 4'hf;
        lane_wdata     = lsu_wdata;
        case (lsu_width)
            2'b00: begin
                lane_be    = 4'b0001 << lsu_addr[1:0];
                lane_wdata = {4{lsu_wdata[7:0]}};
            end
            2'b01: begin
                lane_be        = 4'b0011 << lsu_addr[1:0];
                lane_wdata     = {2{lsu_wdata[15:0]}};
                lsu_misaligned = lsu_addr[0];
            end
            default: lsu_misaligned = (lsu_addr[1:0] != 2'b00);
        endcase
    end

    assign starve_at_limit = (starve_cnt == SW'(STARVE_LIMIT));
    assign lsu_wins        = lsu_req && !(if_req && starve_at_limit);
    assign starve_on_lsu   = !if_req        ? '0 :
                             starve_at_limit ? starve_cnt : starve_cnt + SW'(1);
    assign to_last         = (to_cnt == TW'(TIMEOUT - 1));
    assign read_shifted    = mem_rdata >> {lsu_shift, 3'b000};

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d         = state;
        starve_d        = starve_cnt;
        to_d            = to_cnt;
        post_resp_d     = 1'b0;
        lsu_shift_d     = lsu_shift;
        if_rsp_valid_d  = 1'b0;
        if_rdata_d      = if_rdata;
        if_err_d        = if_err;
        lsu_rsp_valid_d = 1'b0;
        lsu_rdata_d     = lsu_rdata;
        lsu_err_d       = lsu_err;
        mem_req_d       = mem_req;
        mem_addr_d      = mem_addr;
        mem_we_d        = mem_we;
        mem_be_d        = mem_be;
        mem_wdata_d     = mem_wdata;

        case (state)
            IDLE: begin
                // The IDLE cycle right after a response does not arbitrate, so the
                // served requester can drop or re-present req and both compete fairly.
                if (!post_resp) begin
                    if (lsu_wins) begin
                        starve_d    = starve_on_lsu;
                        lsu_shift_d = lsu_addr[1:0];
                        if (lsu_misaligned) begin
                            state_d         = RESP;
                            lsu_rsp_valid_d = 1'b1;
                            lsu_err_d       = 1'b1;
                            lsu_rdata_d     = '0;
                        end else begin
                            state_d     = BUS_LSU;
                            to_d        = '0;
                            mem_req_d   = 1'b1;
                            mem_addr_d  = {lsu_addr[31:2], 2'b00};
                            mem_we_d    = lsu_we;
                            mem_be_d    = lane_be;
                            mem_wdata_d = lane_wdata;
                        end
                    end else if (if_req) begin
                        starve_d    = '0;
                        state_d     = BUS_IF;
                        to_d        = '0;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {if_addr[31:2], 2'b00};
                        mem_we_d    = 1'b0;
                        mem_be_d    = 4'hf;
                        mem_wdata_d = '0;
                    end
                end
            end
            BUS_IF, BUS_LSU: begin
                // An ack arriving on the final timeout cycle still completes normally.
                if (mem_ack || to_last) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state == BUS_LSU) begin
                        lsu_rsp_valid_d = 1'b1;
                        lsu_err_d       = !mem_ack;
                        lsu_rdata_d     = (mem_ack && !mem_we) ? read_shifted : '0;
                    end else begin
                        if_rsp_valid_d = 1'b1;
                        if_err_d       = !mem_ack;
                        if_rdata_d     = mem_ack ? mem_rdata : '0;
                    end
                end else begin
                    to_d = to_cnt + TW'(1);
                end
            end
            RESP: begin
                state_d     = IDLE;
                post_resp_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            starve_cnt    <= '0;
            to_cnt        <= '0;
            post_resp     <= 1'b0;
            lsu_shift     <= '0;
            if_rsp_valid  <= 1'b0;
            if_rdata      <= '0;
            if_err        <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            lsu_rdata     <= '0;
            lsu_err       <= 1'b0;
            mem_req       <= 1'b0;
            mem_addr      <= '0;
            mem_we        <= 1'b0;
            mem_be        <= '0;
            mem_wdata     <= '0;
        end else begin
            state         <= state_d;
            starve_cnt    <= starve_d;
            to_cnt        <= to_d;
            post_resp     <= post_resp_d;
            lsu_shift     <= lsu_shift_d;
            if_rsp_valid  <= if_rsp_valid_d;
            if_rdata      <= if_rdata_d;
            if_err        <= if_err_d;
            lsu_rsp_valid <= lsu_rsp_valid_d;
            lsu_rdata     <= lsu_rdata_d;
            lsu_err       <= lsu_err_d;
            mem_req       <= mem_req_d;
            mem_addr      <= mem_addr_d;
            mem_we        <= mem_we_d;
            mem_be        <= mem_be_d;
            mem_wdata     <= mem_wdata_d;
        end
    end

endmodule
